lck_sweep_sequencer: RTL
========================

Name: lck_sweep_sequencer

Overview:
- Sequences the lock-in correlator through a range of DDS N2 (period length) settings.
- For each point it pushes the lock-in configuration, drives DDS N2, waits a programmed settle time, averages the squared amplitude output and emits one result word on an AXI-Stream master with backpressure.
- Sits between the PS config bus and the lock-in core/DDS. Replaces manual host-driven frequency stepping.

Parameters:
- configuration_address, 1000, config bus address of this block.
- LCK_CFG_ADDRESS, 999, address driven on the lock-in config bus.
- AM2_DATA_WIDTH, 48, width of the A2 input.
- AVG2_MAX, 16, maximum log2 averaging count.
- N2_WIDTH, 16, DDS N2 width.

Ports:
- a_clk  in  1  clock
- a_rst  in  1  synchronous active-high reset
- config_addr  in  32  PS config address
- config_data  in  512  PS config data
- lck_config_addr  out  32  lock-in config address
- lck_config_data  out  512  lock-in config data
- M_AXIS_DDS_N2_tdata  out  16  DDS N2 to DDS and lock-in
- M_AXIS_DDS_N2_tvalid  out  1  always 1
- S_AXIS_A2_tdata  in  48  lock-in amplitude squared
- S_AXIS_A2_tvalid  in  1  sample qualifier
- M_AXIS_RES_tdata  out  64  result {N2[15:0], avgA2[47:0]}
- M_AXIS_RES_tvalid  out  1  result valid
- M_AXIS_RES_tready  in  1  downstream ready
- busy  out  1  sweep active
- done  out  1  sticky sweep-complete flag

Behaviour:
- Config capture happens on the cycle where config_addr == configuration_address. Words:
  - w0: bit0 start, bit1 abort, bit2 loop.
  - w1[15:0]: n2_start.
  - w2[15:0]: n2_stop.
  - w3: settle_cycles.
  - w4[4:0]: avg2, clamped to AVG2_MAX.
  - w5: lck_config.
  - w6: lck_gain.
- start and abort are one-shot: they act only in the capture cycle. All other fields are latched.
- Reset values: state IDLE; lck_config_addr 0; lck_config_data 0; N2 tdata 0; RES tvalid 0; RES tdata 0; busy 0; done 0; accumulator 0.
- IDLE:
  - start → load n2 = n2_start, clear done, set busy → CONFIG.
  - start while busy is ignored.
- CONFIG (1 cycle):
  - lck_config_addr = LCK_CFG_ADDRESS.
  - lck_config_data = {448'b0, lck_gain, lck_config}.
  - M_AXIS_DDS_N2_tdata = n2.
  - Next: load settle counter (settle_cycles == 0 is treated as 1) → SETTLE.
  - In all other states lck_config_addr = 0.
- SETTLE: decrement once per cycle; at 1 → clear accumulator and sample counter → ACCUM.
- ACCUM:
  - On each S_AXIS_A2_tvalid, acc += A2. acc is unsigned, AM2_DATA_WIDTH+AVG2_MAX bits, and never overflows.
  - After 2^avg2 samples → EMIT.
- EMIT:
  - tdata = {n2, acc >> avg2} (truncating), held stable; tvalid = 1.
  - On tvalid & tready → NEXT. tvalid deasserts the following cycle.
- NEXT:
  - n2 == n2_stop → if loop, go to CONFIG with n2 = n2_start; otherwise set done, clear busy → IDLE.
  - Otherwise n2 += 1 → CONFIG.
  - n2_stop < n2_start with the feature off → single point (n2_start only).
- N2 tdata holds its last value in IDLE.
- Latency per point: 1 (CONFIG) + settle + 2^avg2 valid samples + 1 + handshake wait.
- abort in any state:
  - Next cycle → IDLE, busy 0, tvalid 0.
  - done stays 0.
  - Any result being presented is dropped.
  - Abort has priority over a simultaneous tready.
- Reset mid-operation returns to reset values on the next edge. No partial result is emitted.
- Config writes other than start/abort during a sweep update latched fields. They take effect at the next CONFIG or NEXT.

Optional Feature:
- LCK_SWEEP_DOWN_EN defined: n2_stop < n2_start sweeps descending (n2 -= 1), terminating at n2_stop.
- Not defined: that case runs the single point n2_start only.

Decomposition:
- Package lck_sweep_pkg holds:
  - state enum (IDLE, CONFIG, SETTLE, ACCUM, EMIT, NEXT);
  - config word index constants;
  - result field offsets.
- One sub-module, lck_a2_averager: accumulator, sample counter, shift-divide; start/clear/done handshake.
- FSM and config capture stay in the top level.

Test Plan:
- n2 3..5, settle 4, avg2 2, A2 constant 100, tready=1 → three results {3,100}, {4,100}, {5,100}; done=1; each lck_config_addr pulse lasts 1 cycle with value 999.
- avg2 2, A2 samples 1, 2, 3, 6 with a tvalid gap → avgA2 = 3; the gap is not counted.
- tready held 0 for 10 cycles in EMIT → tdata/tvalid stable; sweep advances only after the handshake.
- abort during SETTLE of point 2 of 1..4 → IDLE next cycle; busy 0; done 0; no further results.
- settle 0, n2 7..7 → settle treated as 1; single result {7,avg}. With LCK_SWEEP_DOWN_EN, n2 5..3 → 5, 4, 3; without it → only 5.
- loop=1, n2 1..2 → results 1, 2, 1, 2 … until abort; a2 of 48'hFFFF_FFFF_FFFF with avg2 16 → no overflow, avg equals the input.

Source files
------------

// File: rtl/lck_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lck_sweep_pkg
// Brief   : Shared types and constants for the lock-in N2 sweep sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package lck_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        SETTLE = 3'd2,
        ACCUM  = 3'd3,
        EMIT   = 3'd4,
        NEXT   = 3'd5
    } state_t;

    localparam int c_CFG_WORD_W = 32;

    localparam int c_W_CTRL     = 0;
    localparam int c_W_N2_START = 1;
    localparam int c_W_N2_STOP  = 2;
    localparam int c_W_SETTLE   = 3;
    localparam int c_W_AVG2     = 4;
    localparam int c_W_LCK_CFG  = 5;
    localparam int c_W_LCK_GAIN = 6;

    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_ABORT = 1;
    localparam int c_CTRL_LOOP  = 2;

    localparam int c_AVG2_W = 5;

    localparam int c_RES_AVG_LSB = 0;
    localparam int c_RES_N2_LSB  = 48;

endpackage
`default_nettype wire

// File: rtl/lck_a2_averager.sv
`default_nettype none
// ============================================================================
// Module  : lck_a2_averager
// Brief   : Accumulates 2^avg2 qualified A2 samples after a clear, then holds
//           the shift-divided mean with o_done high until the next clear.
// Revision: 1.0 - initial release
// ============================================================================
module lck_a2_averager
    import lck_sweep_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int AVG2_MAX   = 16
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [c_AVG2_W-1:0]   i_avg2,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_avg
);

    localparam int c_ACC_W = DATA_WIDTH + AVG2_MAX;
    localparam int c_CNT_W = AVG2_MAX + 1;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_active;
    logic               r_done;

    logic [c_CNT_W-1:0] w_target;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign w_target   = {{(c_CNT_W-1){1'b0}}, 1'b1} << i_avg2;
    assign w_cnt_next = r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};

    // Accumulator is AVG2_MAX bits wider than a sample, so the full run of
    // 2^AVG2_MAX maximum-value samples cannot overflow.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_clr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active && i_valid) begin
            r_acc <= r_acc + {{AVG2_MAX{1'b0}}, i_data};
            r_cnt <= w_cnt_next;
            if (w_cnt_next == w_target) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_avg  = DATA_WIDTH'(r_acc >> i_avg2);

endmodule
`default_nettype wire

// File: rtl/lck_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lck_sweep_sequencer
// Brief   : Steps DDS N2 over a range, configures the lock-in per point,
//           averages A2 and streams {N2, avgA2} results.
//           Optional macro LCK_SWEEP_DOWN_EN enables descending sweeps.
// Revision: 1.0 - initial release
// ============================================================================
module lck_sweep_sequencer
    import lck_sweep_pkg::*;
#(
    parameter int configuration_address = 1000,
    parameter int LCK_CFG_ADDRESS       = 999,
    parameter int AM2_DATA_WIDTH        = 48,
    parameter int AVG2_MAX              = 16,
    parameter int N2_WIDTH              = 16
) (
    input  logic                               a_clk,
    input  logic                               a_rst,
    input  logic [31:0]                        config_addr,
    input  logic [511:0]                       config_data,
    output logic [31:0]                        lck_config_addr,
    output logic [511:0]                       lck_config_data,
    output logic [N2_WIDTH-1:0]                M_AXIS_DDS_N2_tdata,
    output logic                               M_AXIS_DDS_N2_tvalid,
    input  logic [AM2_DATA_WIDTH-1:0]          S_AXIS_A2_tdata,
    input  logic                               S_AXIS_A2_tvalid,
    output logic [N2_WIDTH+AM2_DATA_WIDTH-1:0] M_AXIS_RES_tdata,
    output logic                               M_AXIS_RES_tvalid,
    input  logic                               M_AXIS_RES_tready,
    output logic                               busy,
    output logic                               done
);

    localparam logic [c_AVG2_W-1:0] c_AVG2_LIMIT = c_AVG2_W'(AVG2_MAX);

    state_t r_state;
    state_t w_next;

    logic                               r_loop;
    logic [N2_WIDTH-1:0]                r_n2_start;
    logic [N2_WIDTH-1:0]                r_n2_stop;
    logic [31:0]                        r_settle_cycles;
    logic [c_AVG2_W-1:0]                r_avg2;
    logic [31:0]                        r_lck_config;
    logic [31:0]                        r_lck_gain;

    logic [N2_WIDTH-1:0]                r_n2;
    logic [31:0]                        r_settle_cnt;
    logic [N2_WIDTH+AM2_DATA_WIDTH-1:0] r_res_tdata;
    logic                               r_res_tvalid;
    logic                               r_busy;
    logic                               r_done;

    logic                               w_cap;
    logic                               w_start;
    logic                               w_abort;
    logic [N2_WIDTH-1:0]                w_n2_start_in;
    logic [c_AVG2_W-1:0]                w_avg2_raw;
    logic [c_AVG2_W-1:0]                w_avg2_clamped;
    logic                               w_last;
    logic [N2_WIDTH-1:0]                w_n2_step;
    logic                               w_settle_end;
    logic                               w_avg_clr;
    logic                               w_avg_done;
    logic [AM2_DATA_WIDTH-1:0]          w_avg;
    logic                               w_unused_cfg;

    assign w_cap   = (config_addr == 32'(configuration_address));
    assign w_start = w_cap && config_data[c_W_CTRL*c_CFG_WORD_W + c_CTRL_START];
    assign w_abort = w_cap && config_data[c_W_CTRL*c_CFG_WORD_W + c_CTRL_ABORT];

    assign w_n2_start_in  = config_data[c_W_N2_START*c_CFG_WORD_W +: N2_WIDTH];
    assign w_avg2_raw     = config_data[c_W_AVG2*c_CFG_WORD_W +: c_AVG2_W];
    assign w_avg2_clamped = (w_avg2_raw > c_AVG2_LIMIT) ? c_AVG2_LIMIT : w_avg2_raw;

    assign w_unused_cfg = ^{config_data[511:224], config_data[159:133],
                            config_data[95:80], config_data[63:48], config_data[31:3]};

    // Range comparisons (not equality) keep the sweep terminating even if the
    // stop value is rewritten behind the current point mid-sweep.
`ifdef LCK_SWEEP_DOWN_EN
    logic w_down;
    assign w_down    = (r_n2_stop < r_n2_start);
    assign w_last    = w_down ? (r_n2 <= r_n2_stop) : (r_n2 >= r_n2_stop);
    assign w_n2_step = w_down ? (r_n2 - 1'b1) : (r_n2 + 1'b1);
`else
    assign w_last    = (r_n2 >= r_n2_stop);
    assign w_n2_step = r_n2 + 1'b1;
`endif

    assign w_settle_end = (r_settle_cnt <= 32'd1);

    lck_a2_averager #(
        .DATA_WIDTH (AM2_DATA_WIDTH),
        .AVG2_MAX   (AVG2_MAX)
    ) u_averager (
        .a_clk   (a_clk),
        .a_rst   (a_rst),
        .i_clr   (w_avg_clr),
        .i_valid (S_AXIS_A2_tvalid),
        .i_data  (S_AXIS_A2_tdata),
        .i_avg2  (r_avg2),
        .o_done  (w_avg_done),
        .o_avg   (w_avg)
    );

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = CONFIG;
            CONFIG:  w_next = SETTLE;
            SETTLE:  if (w_settle_end) w_next = ACCUM;
            ACCUM:   if (w_avg_done) w_next = EMIT;
            EMIT:    if (M_AXIS_RES_tready) w_next = NEXT;
            NEXT:    w_next = (w_last && !r_loop) ? IDLE : CONFIG;
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        w_avg_clr       = (r_state == SETTLE) && w_settle_end;
        lck_config_addr = '0;
        lck_config_data = '0;
        if (r_state == CONFIG) begin
            lck_config_addr = 32'(LCK_CFG_ADDRESS);
            lck_config_data = {448'b0, r_lck_gain, r_lck_config};
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_loop          <= 1'b0;
            r_n2_start      <= '0;
            r_n2_stop       <= '0;
            r_settle_cycles <= '0;
            r_avg2          <= '0;
            r_lck_config    <= '0;
            r_lck_gain      <= '0;
            r_n2            <= '0;
            r_settle_cnt    <= '0;
            r_res_tdata     <= '0;
            r_res_tvalid    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_cap) begin
                r_loop          <= config_data[c_W_CTRL*c_CFG_WORD_W + c_CTRL_LOOP];
                r_n2_start      <= w_n2_start_in;
                r_n2_stop       <= config_data[c_W_N2_STOP*c_CFG_WORD_W +: N2_WIDTH];
                r_settle_cycles <= config_data[c_W_SETTLE*c_CFG_WORD_W +: 32];
                r_avg2          <= w_avg2_clamped;
                r_lck_config    <= config_data[c_W_LCK_CFG*c_CFG_WORD_W +: 32];
                r_lck_gain      <= config_data[c_W_LCK_GAIN*c_CFG_WORD_W +: 32];
            end
            case (r_state)
                IDLE: begin
                    if (w_start && !w_abort) begin
                        r_n2   <= w_n2_start_in;
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                CONFIG: begin
                    r_settle_cnt <= (r_settle_cycles == 32'd0) ? 32'd1 : r_settle_cycles;
                end
                SETTLE: begin
                    if (!w_settle_end) begin
                        r_settle_cnt <= r_settle_cnt - 32'd1;
                    end
                end
                ACCUM: begin
                    if (w_avg_done) begin
                        r_res_tdata  <= {r_n2, w_avg};
                        r_res_tvalid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (M_AXIS_RES_tready) begin
                        r_res_tvalid <= 1'b0;
                    end
                end
                NEXT: begin
                    if (w_last) begin
                        if (r_loop) begin
                            r_n2 <= r_n2_start;
                        end else begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_n2 <= w_n2_step;
                    end
                end
                default: ;
            endcase
            // Abort drops any pending result and never reports completion.
            if (w_abort) begin
                r_busy       <= 1'b0;
                r_res_tvalid <= 1'b0;
                r_done       <= r_done;
            end
        end
    end

    assign M_AXIS_DDS_N2_tdata  = r_n2;
    assign M_AXIS_DDS_N2_tvalid = 1'b1;
    assign M_AXIS_RES_tdata     = r_res_tdata;
    assign M_AXIS_RES_tvalid    = r_res_tvalid;
    assign busy                 = r_busy;
    assign done                 = r_done;

endmodule
`default_nettype wire
